// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_event_decoder
// Description : PS/2 scan-byte parser producing key press/release events for
//               ten mapped keys, with a live pressed bitmap and an event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_decoder #(
    parameter int FIFO_DEPTH       = 4,
    parameter int PREFIX_TIMEOUT_W = 20
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [7:0] scan_byte,
    input  logic       scan_flag,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [3:0] evt_code,
    output logic       evt_make,
    output logic [9:0] key_state,
    output logic       fifo_ovf
);

    localparam int                      c_AW    = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]           c_FULL  = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [PREFIX_TIMEOUT_W-1:0] c_TMAX = {PREFIX_TIMEOUT_W{1'b1}};

    localparam logic [7:0] c_EXT_PFX = 8'hE0;
    localparam logic [7:0] c_BRK_PFX = 8'hF0;
    localparam logic [7:0] c_PAU_PFX = 8'hE1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    // Returns {hit, index} for single-byte codes.
    function automatic logic [4:0] map_normal(input logic [7:0] b);
        case (b)
            8'h1D:   return {1'b1, 4'd0};
            8'h1C:   return {1'b1, 4'd1};
            8'h1B:   return {1'b1, 4'd2};
            8'h23:   return {1'b1, 4'd3};
            8'h29:   return {1'b1, 4'd4};
            8'h76:   return {1'b1, 4'd5};
            default: return 5'd0;
        endcase
    endfunction

    // Returns {hit, index} for codes following an E0 prefix.
    function automatic logic [4:0] map_ext(input logic [7:0] b);
        case (b)
            8'h75:   return {1'b1, 4'd6};
            8'h6B:   return {1'b1, 4'd7};
            8'h72:   return {1'b1, 4'd8};
            8'h74:   return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

    state_t                      r_state;
    logic [2:0]                  r_skip_cnt;
    logic [PREFIX_TIMEOUT_W-1:0] r_timeout;
    logic                        r_flag_d;

    logic       w_byte_evt;
    logic       w_is_prefix;
    logic [4:0] w_map;
    logic       w_dec_hit;
    logic [3:0] w_dec_idx;
    logic       w_dec_make;
    logic       w_push;

    assign w_byte_evt  = scan_flag & ~r_flag_d;
    assign w_is_prefix = (scan_byte == c_EXT_PFX) || (scan_byte == c_BRK_PFX) ||
                         (scan_byte == c_PAU_PFX);

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_flag_d <= 1'b1;
        end else begin
            r_flag_d <= scan_flag;
        end
    end

    // Prefix bytes never decode; in EXT an E1 simply misses the extended map.
    always_comb begin
        w_map      = 5'd0;
        w_dec_make = 1'b0;
        if (w_byte_evt && !w_is_prefix) begin
            case (r_state)
                ST_IDLE: begin
                    w_map      = map_normal(scan_byte);
                    w_dec_make = 1'b1;
                end
                ST_EXT: begin
                    w_map      = map_ext(scan_byte);
                    w_dec_make = 1'b1;
                end
                ST_BRK: begin
                    w_map      = map_normal(scan_byte);
                    w_dec_make = 1'b0;
                end
                ST_EXT_BRK: begin
                    w_map      = map_ext(scan_byte);
                    w_dec_make = 1'b0;
                end
                default: begin
                    w_map      = 5'd0;
                    w_dec_make = 1'b0;
                end
            endcase
        end
    end

    assign w_dec_hit = w_map[4];
    assign w_dec_idx = w_map[3:0];

    // Typematic repeats and releases of keys not held produce no event.
    assign w_push = w_dec_hit &
                    (w_dec_make ? ~key_state[w_dec_idx] : key_state[w_dec_idx]);

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_state    <= ST_IDLE;
            r_skip_cnt <= 3'd0;
            r_timeout  <= '0;
        end else begin
            if (r_state == ST_IDLE || w_byte_evt || r_timeout == c_TMAX) begin
                r_timeout <= '0;
            end else begin
                r_timeout <= r_timeout + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_byte_evt) begin
                        if (scan_byte == c_EXT_PFX) begin
                            r_state <= ST_EXT;
                        end else if (scan_byte == c_BRK_PFX) begin
                            r_state <= ST_BRK;
                        end else if (scan_byte == c_PAU_PFX) begin
                            r_state    <= ST_SKIP;
                            r_skip_cnt <= 3'd7;
                        end
                    end
                end
                ST_EXT: begin
                    if (w_byte_evt) begin
                        if (scan_byte == c_BRK_PFX) begin
                            r_state <= ST_EXT_BRK;
                        end else if (scan_byte != c_EXT_PFX) begin
                            r_state <= ST_IDLE;
                        end
                    end else if (r_timeout == c_TMAX) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    if (w_byte_evt || r_timeout == c_TMAX) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    if (w_byte_evt) begin
                        if (r_skip_cnt == 3'd1) begin
                            r_state    <= ST_IDLE;
                            r_skip_cnt <= 3'd0;
                        end else begin
                            r_skip_cnt <= r_skip_cnt - 3'd1;
                        end
                    end else if (r_timeout == c_TMAX) begin
                        r_state    <= ST_IDLE;
                        r_skip_cnt <= 3'd0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_skip_cnt <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            key_state <= 10'd0;
        end else if (w_push) begin
            key_state[w_dec_idx] <= w_dec_make;
        end
    end

    // ---------------- first-word-fall-through event FIFO ----------------
    logic [4:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;

    assign w_full = (r_count == c_FULL);
    assign w_pop  = evt_valid & evt_ready;
    assign w_wr   = w_push & (~w_full | w_pop);

    always_ff @(posedge CLK100MHZ) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {w_dec_idx, w_dec_make};
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            fifo_ovf <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                fifo_ovf <= 1'b1;
            end
        end
    end

    assign evt_valid = (r_count != '0);
    assign evt_code  = evt_valid ? r_mem[r_rd_ptr][4:1] : 4'd0;
    assign evt_make  = evt_valid ? r_mem[r_rd_ptr][0]   : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_decoder
// Description : Scoreboard bench for key_event_decoder with directed scan bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] scan_byte;
    logic       scan_flag;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_code;
    logic       evt_make;
    logic [9:0] key_state;
    logic       fifo_ovf;

    int         checks   = 0;
    int         failures = 0;
    logic [4:0] exp_q[$];

    key_event_decoder #(
        .FIFO_DEPTH       (4),
        .PREFIX_TIMEOUT_W (6)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .scan_byte  (scan_byte),
        .scan_flag  (scan_flag),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_make   (evt_make),
        .key_state  (key_state),
        .fifo_ovf   (fifo_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every accepted head event is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual=code %0d make %0b required=none",
                         evt_code, evt_make);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({evt_code, evt_make} !== e) begin
                    failures++;
                    $display("FAIL event actual=code %0d make %0b required=code %0d make %0b",
                             evt_code, evt_make, e[4:1], e[0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int hold = 2);
        scan_byte = b;
        scan_flag = 1'b1;
        tick(hold);
        scan_flag = 1'b0;
        tick(2);
    endtask

    task automatic expect_evt(input int code, input logic make);
        exp_q.push_back({4'(code), make});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick(1);
            t++;
        end
        tick(2);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] keys [5];
        keys = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29};

        rst_n     = 1'b0;
        scan_flag = 1'b0;
        scan_byte = 8'h00;
        evt_ready = 1'b1;
        tick(3);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_make", evt_make, 0);
        check("rst_keys", key_state, 0);
        check("rst_ovf", fifo_ovf, 0);
        rst_n = 1'b1;
        tick(2);

        // Normal make, typematic repeat, break
        expect_evt(0, 1'b1);
        send(8'h1D);
        check("w_press", key_state, 10'h001);
        send(8'h1D);
        check("w_repeat", key_state, 10'h001);
        expect_evt(0, 1'b0);
        send(8'hF0);
        send(8'h1D);
        check("w_release", key_state, 10'h000);
        drain("drain_w");

        // Extended keys and unmapped extended code
        expect_evt(6, 1'b1);
        send(8'hE0); send(8'h75);
        check("up_press", key_state, 10'h040);
        expect_evt(6, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("up_release", key_state, 10'h000);
        send(8'hE0); send(8'h12);
        drain("drain_ext");
        check("unmapped_ext", key_state, 10'h000);

        // Overflow with stalled consumer
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_evt(i, 1'b1);
            send(keys[i]);
        end
        check("ovf_before", fifo_ovf, 0);
        send(keys[4]);
        check("ovf_set", fifo_ovf, 1);
        check("ovf_keys", key_state, 10'h01F);
        check("stall_valid", evt_valid, 1);
        check("stall_code", evt_code, 0);
        check("stall_make", evt_make, 1);
        evt_ready = 1'b1;
        drain("drain_ovf");
        check("empty_valid", evt_valid, 0);
        check("empty_code", evt_code, 0);
        check("empty_make", evt_make, 0);
        for (int i = 0; i < 5; i++) begin
            expect_evt(i, 1'b0);
            send(8'hF0); send(keys[i]);
        end
        drain("drain_rel1");
        check("rel1_keys", key_state, 10'h000);

        // Push and pop in the same cycle while full: nothing lost
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_evt(i, 1'b1);
            send(keys[i]);
        end
        expect_evt(4, 1'b1);
        evt_ready = 1'b1;
        send(keys[4]);
        drain("drain_full_pp");
        for (int i = 0; i < 5; i++) begin
            expect_evt(i, 1'b0);
            send(8'hF0); send(keys[i]);
        end
        drain("drain_rel2");

        // Pause sequence discarded, next byte parsed normally
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("pause_keys", key_state, 10'h000);
        expect_evt(1, 1'b1);
        send(8'h1C);
        drain("drain_pause");
        check("pause_a", key_state, 10'h002);
        expect_evt(1, 1'b0);
        send(8'hF0); send(8'h1C);
        drain("drain_a_rel");

        // Break prefix timeout, then break before timeout
        send(8'hF0);
        tick(80);
        expect_evt(2, 1'b1);
        send(8'h1B);
        drain("drain_tmo");
        check("tmo_keys", key_state, 10'h004);
        send(8'hF0);
        tick(20);
        expect_evt(2, 1'b0);
        send(8'h1B);
        drain("drain_no_tmo");
        check("no_tmo_keys", key_state, 10'h000);

        // SKIP state also times out
        send(8'hE1);
        tick(80);
        expect_evt(3, 1'b1);
        send(8'h23);
        drain("drain_skip_tmo");
        expect_evt(3, 1'b0);
        send(8'hF0); send(8'h23);

        // Long-held flag gives a single byte event
        expect_evt(3, 1'b1);
        send(8'h23, 50);
        drain("drain_hold");
        check("hold_keys", key_state, 10'h008);
        expect_evt(3, 1'b0);
        send(8'hF0); send(8'h23);
        drain("drain_hold_rel");

        // Reset with scan_flag high across release
        scan_byte = 8'h1D;
        scan_flag = 1'b1;
        rst_n     = 1'b0;
        tick(3);
        check("rst2_ovf", fifo_ovf, 0);
        rst_n = 1'b1;
        tick(10);
        check("rst_flag_valid", evt_valid, 0);
        check("rst_flag_keys", key_state, 10'h000);
        scan_flag = 1'b0;
        tick(2);

        // Reset mid-sequence abandons the prefix
        send(8'hE0);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        send(8'h75);
        tick(5);
        check("mid_rst_ext", key_state, 10'h000);
        send(8'hE0); send(8'hF0);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        expect_evt(0, 1'b1);
        send(8'h1D);
        drain("drain_mid_rst");
        check("mid_rst_brk", key_state, 10'h001);

        tick(10);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the event FIFO depth (power of two, 2..16).
REQ-002 Parameter PREFIX_TIMEOUT_W, default 20, SHALL set the prefix-timeout counter width (2^20 cycles, about 10.5 ms at 100 MHz).
REQ-003 CLK100MHZ  in  1  SHALL be the single clock; all state SHALL change on its rising edge only.
REQ-004 CPU_RESETN  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 scan_byte  in  8  SHALL carry the latest PS/2 scan byte (keycode[7:0] of the receiver).
REQ-006 scan_flag  in  1  SHALL be the receiver byte-done flag; a new byte is signalled by its rising edge.
REQ-007 evt_valid  out  1  SHALL indicate that the FIFO head holds an event.
REQ-008 evt_ready  in  1  SHALL be the consumer acceptance; the head pops on evt_valid & evt_ready.
REQ-009 evt_code  out  4  SHALL be the key index of the head event.
REQ-010 evt_make  out  1  SHALL be 1 for a press event and 0 for a release event at the head.
REQ-011 key_state  out  10  SHALL be the live pressed bitmap, indexed by key index.
REQ-012 fifo_ovf  out  1  SHALL be a sticky flag set when an event is dropped.

Function
REQ-013 Key map: 0 W=1D, 1 A=1C, 2 S=1B, 3 D=23, 4 Space=29, 5 Esc=76, 6 Up=E0 75, 7 Left=E0 6B, 8 Down=E0 72, 9 Right=E0 74; all other codes SHALL be ignored.
REQ-014 The block SHALL hold a flag_d register (flag_d <= scan_flag); byte_evt = scan_flag & ~flag_d SHALL be the byte event.
REQ-015 Parser FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
REQ-016 IDLE on byte_evt: E0 -> EXT; F0 -> BRK; E1 -> SKIP with skip_cnt=7; otherwise decode a normal make and stay in IDLE.
REQ-017 EXT on byte_evt: F0 -> EXT_BRK; E0 -> EXT; otherwise decode an extended make and go to IDLE.
REQ-018 BRK on byte_evt: E0, F0 or E1 -> IDLE with no event (protocol error); otherwise decode a normal break and go to IDLE.
REQ-019 EXT_BRK on byte_evt: E0, F0 or E1 -> IDLE with no event; otherwise decode an extended break and go to IDLE.
REQ-020 SKIP SHALL discard bytes, decrementing skip_cnt on each byte_evt, and go to IDLE when the byte arrives with skip_cnt=1 (Pause sequence, 8 bytes total).
REQ-021 In EXT, BRK, EXT_BRK and SKIP a timeout counter SHALL count cycles without byte_evt; on reaching 2^PREFIX_TIMEOUT_W-1 the FSM SHALL go to IDLE; the counter clears on every byte_evt and in IDLE.
REQ-022 A mapped make with key_state[i]=0 SHALL set key_state[i] and push {i,1}; a make with key_state[i]=1 (typematic repeat) SHALL do nothing.
REQ-023 A mapped break with key_state[i]=1 SHALL clear key_state[i] and push {i,0}; a break with key_state[i]=0 SHALL do nothing.
REQ-024 Latency: for a byte_evt at edge k, key_state and the FIFO write SHALL update at edge k; evt_valid SHALL be 1 after edge k when the FIFO was empty.
REQ-025 The FIFO SHALL be first-word-fall-through; evt_code and evt_make SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-026 A push with FIFO full and no pop in the same cycle SHALL drop the event and set fifo_ovf; key_state SHALL still update.
REQ-027 A push and pop in the same cycle SHALL both occur, including when the FIFO is full, with no drop and unchanged occupancy.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with log2(FIFO_DEPTH)+1 bits.
REQ-029 evt_code and evt_make SHALL read 0 when evt_valid=0.

Reset
REQ-030 While CPU_RESETN=0 at an edge, the block SHALL set: FSM=IDLE, skip_cnt=0, timeout=0, FIFO empty, evt_valid=0, evt_code=0, evt_make=0, key_state=0, fifo_ovf=0.
REQ-031 Reset SHALL set flag_d=1, so a scan_flag held high across reset release SHALL NOT create a byte_evt.
REQ-032 Reset asserted mid-sequence (for example after E0 F0) SHALL abandon the sequence; the next byte SHALL be parsed from IDLE.

Verification
REQ-033 Bytes 1D, 1D, F0 1D with evt_ready=1 -> events {0,1}, {0,0}; key_state[0] goes 1 then 0; the repeat produces no event.
REQ-034 Bytes E0 75, E0 F0 75 -> events {6,1}, {6,0}; an unmapped E0 12 produces no event.
REQ-035 evt_ready=0 with 5 distinct makes -> 4 events held, the fifth dropped, fifo_ovf=1, key_state=all five bits set; then drain -> 4 events in order.
REQ-036 Bytes E1 14 77 E1 F0 14 F0 77 then 1C -> only event {1,1}.
REQ-037 Byte F0, then no byte for 2^20 cycles, then 1B -> event {2,1} (make, not break).
REQ-038 scan_flag held high for 50 cycles on byte 23 -> exactly one event {3,1}; reset released with scan_flag=1 -> no event.
